// File: rtl/div_pkg.sv
// ============================================================
// div_pkg : shared types and widths for the 12x6 divider
// rev 1.0
// ============================================================
`default_nettype none

package div_pkg;

  localparam int DIVIDEND_W_DEFAULT = 12;
  localparam int DIVISOR_W_DEFAULT  = 6;
  localparam int CNT_W              = $clog2(DIVIDEND_W_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================
// div_step : one combinational restoring-division iteration
// rev 1.0
// ============================================================
`default_nettype none

module div_step #(
  parameter int DIVISOR_W = div_pkg::DIVISOR_W_DEFAULT
) (
  input  logic [DIVISOR_W-1:0] partial_rem,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] new_rem,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] trial;

  // When trial >= divisor the difference is below divisor, so it fits in
  // DIVISOR_W bits and the subtraction can be done at that width.
  always_comb begin
    trial = {partial_rem, next_bit};
    q_bit = (trial >= {1'b0, divisor});
    if (q_bit) begin
      new_rem = trial[DIVISOR_W-1:0] - divisor;
    end else begin
      new_rem = trial[DIVISOR_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider_12x6.sv
// ============================================================
// seq_divider_12x6 : sequential restoring divider, valid/ready I/O
// rev 1.0
// ============================================================
`default_nettype none

module seq_divider_12x6 #(
  parameter int DIVIDEND_W = div_pkg::DIVIDEND_W_DEFAULT,
  parameter int DIVISOR_W  = div_pkg::DIVISOR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  import div_pkg::*;

  localparam int CW = $clog2(DIVIDEND_W);

  state_t                state;
  state_t                state_nx;
  logic [CW-1:0]         cnt;
  logic [DIVISOR_W-1:0]  prem;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVIDEND_W-1:0] qsr;
  logic                  dz_pend;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .partial_rem (prem),
    .next_bit    (qsr[DIVIDEND_W-1]),
    .divisor     (dsr),
    .new_rem     (step_rem),
    .q_bit       (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A zero divisor takes a single CALC cycle (counter loaded with 0) so the
  // result appears one clock after acceptance; the step result is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prem        <= '0;
      dsr         <= '0;
      qsr         <= '0;
      dz_pend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsr     <= divisor;
            qsr     <= dividend;
            prem    <= '0;
            dz_pend <= (divisor == '0);
            cnt     <= (divisor == '0) ? '0 : CW'(DIVIDEND_W - 1);
          end
        end
        CALC: begin
          prem <= step_rem;
          qsr  <= {qsr[DIVIDEND_W-2:0], step_q};
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (dz_pend) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= {qsr[DIVIDEND_W-2:0], step_q};
            remainder   <= step_rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_12x6.sv
// ============================================================
// tb_seq_divider_12x6 : directed vectors and handshake corner cases
// rev 1.0
// ============================================================
`default_nettype none

module tb_seq_divider_12x6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] dividend = '0;
  logic [5:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] quotient;
  logic [5:0]  remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] dvd;
    logic [5:0]  dvs;
    logic [11:0] q;
    logic [5:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  seq_divider_12x6 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present operands for one edge, then count edges until out_valid (bounded).
  task automatic issue(input logic [11:0] a, input logic [5:0] b, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", int'(in_ready), 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_after_consume", int'(out_valid), 0);
    check("in_ready_after_consume", int'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[8];
    int   lat;

    vecs[0] = '{12'd1936, 6'd44, 12'd44,   6'd0,  1'b0, 12};
    vecs[1] = '{12'd1365, 6'd63, 12'd21,   6'd42, 1'b0, 12};
    vecs[2] = '{12'd1013, 6'd46, 12'd22,   6'd1,  1'b0, 12};
    vecs[3] = '{12'd4095, 6'd1,  12'd4095, 6'd0,  1'b0, 12};
    vecs[4] = '{12'd0,    6'd45, 12'd0,    6'd0,  1'b0, 12};
    vecs[5] = '{12'd62,   6'd63, 12'd0,    6'd62, 1'b0, 12};
    vecs[6] = '{12'd100,  6'd0,  12'hFFF,  6'd0,  1'b1, 1};
    vecs[7] = '{12'd2047, 6'd32, 12'd63,   6'd31, 1'b0, 12};

    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_div_by_zero", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].dvd, vecs[i].dvs, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_quotient", i), int'(quotient), int'(vecs[i].q));
      check($sformatf("v%0d_remainder", i), int'(remainder), int'(vecs[i].r));
      check($sformatf("v%0d_div_by_zero", i), int'(div_by_zero), int'(vecs[i].dz));
      consume();
    end

    // Back-pressure: result held for 5 clocks, stray in_valid ignored.
    issue(12'd235, 6'd5, lat);
    check("bp_latency", lat, 12);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k == 2);
      dividend = 12'd100;
      divisor  = 6'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_quotient", int'(quotient), 47);
      check("bp_remainder", int'(remainder), 0);
      check("bp_div_by_zero", int'(div_by_zero), 0);
    end
    consume();
    check("bp_quotient_retained", int'(quotient), 47);

    // Reset in the middle of CALC, then a fresh operation.
    issue(12'd1936, 6'd44, lat);
    consume();
    @(negedge clk);
    dividend = 12'd1936;
    divisor  = 6'd44;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_div_by_zero", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(12'd1365, 6'd63, lat);
    check("post_rst_latency", lat, 12);
    check("post_rst_quotient", int'(quotient), 21);
    check("post_rst_remainder", int'(remainder), 42);
    check("post_rst_div_by_zero", int'(div_by_zero), 0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
